// File: rtl/wgt_dbuf.sv
// Double-buffered weight store: a shadow bank loads taps serially while the
// active bank drives wgt_out; a swap promotes a complete shadow set in one edge.
module wgt_dbuf #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW-1:0]       wgt_input,
  input  logic                wgt_valid,
  output logic                wgt_ready,
  input  logic                wgt_swap,
  input  logic                wgt_clr,
  output logic [DEPTH*DW-1:0] wgt_out,
  output logic                shadow_full,
  output logic                swap_ack,
  output logic                active_vld
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic {LOAD, FULL} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] active [DEPTH];
  logic          accept, swap_ok;

  // Clear outranks both swap and load, so an offered word is dropped with it.
  assign accept  = wgt_valid && wgt_ready && !wgt_clr;
  assign swap_ok = wgt_swap && (state == FULL) && !wgt_clr;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // NOTE: next-state defaults to the current state before the case, so no
  // path leaves state_nxt unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (accept && count == LAST) state_nxt = FULL;
      FULL: if (wgt_clr || swap_ok)      state_nxt = LOAD;
      default:                           state_nxt = LOAD;
    endcase
  end

  always_comb begin
    wgt_ready   = (state == LOAD) && !rst;
    shadow_full = (state == FULL);
  end

  // NOTE: both banks are small register arrays, not RAM, so resetting them
  // is cheap and guarantees wgt_out reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      swap_ack   <= 1'b0;
      active_vld <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      swap_ack <= 1'b0;
      if (wgt_clr) begin
        count <= '0;
        for (int k = 0; k < DEPTH; k++) shadow[k] <= '0;
      end else if (swap_ok) begin
        count      <= '0;
        swap_ack   <= 1'b1;
        active_vld <= 1'b1;
        for (int k = 0; k < DEPTH; k++) active[k] <= shadow[k];
      end else if (accept) begin
        count     <= count + 1'b1;
        shadow[0] <= wgt_input;
        for (int k = 1; k < DEPTH; k++) shadow[k] <= shadow[k-1];
      end
    end
  end

  always_comb begin
    wgt_out = '0;
    for (int k = 0; k < DEPTH; k++) wgt_out[k*DW +: DW] = active[k];
  end

endmodule

// File: tb/tb_wgt_dbuf.sv
// Scoreboard bench for wgt_dbuf: a queue-based model predicts each promoted
// set, and a negedge monitor compares outputs and pops on every swap_ack.
module tb_wgt_dbuf;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int OW    = DEPTH * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] wgt_input = '0;
  logic          wgt_valid = 1'b0;
  logic          wgt_ready;
  logic          wgt_swap = 1'b0;
  logic          wgt_clr = 1'b0;
  logic [OW-1:0] wgt_out;
  logic          shadow_full;
  logic          swap_ack;
  logic          active_vld;

  wgt_dbuf #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wgt_input(wgt_input), .wgt_valid(wgt_valid),
    .wgt_ready(wgt_ready), .wgt_swap(wgt_swap), .wgt_clr(wgt_clr),
    .wgt_out(wgt_out), .shadow_full(shadow_full), .swap_ack(swap_ack),
    .active_vld(active_vld)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: loaded words in arrival order, the promoted set, and pending acks.
  logic [DW-1:0] sh [$];
  logic [OW-1:0] m_act = '0;
  logic          m_vld = 1'b0;
  logic          m_ack = 1'b0;
  logic [OW-1:0] exp_q [$];
  bit            mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Newest word lands in tap 0, so tap k holds the (DEPTH-1-k)-th word loaded.
  function automatic logic [OW-1:0] pack_set();
    logic [OW-1:0] p = '0;
    for (int k = 0; k < DEPTH; k++) p[k*DW +: DW] = sh[DEPTH-1-k];
    return p;
  endfunction

  task automatic step(input bit r, input bit v, input logic [DW-1:0] d,
                      input bit s, input bit c);
    rst = r; wgt_valid = v; wgt_input = d; wgt_swap = s; wgt_clr = c;
    @(posedge clk);
    m_ack = 1'b0;
    if (r) begin
      sh.delete(); m_act = '0; m_vld = 1'b0;
    end else if (c) begin
      sh.delete();
    end else if (s && sh.size() == DEPTH) begin
      m_act = pack_set(); m_vld = 1'b1; m_ack = 1'b1;
      exp_q.push_back(m_act);
      sh.delete();
    end else if (v && sh.size() < DEPTH) begin
      sh.push_back(d);
    end
    mon_en = 1'b1;
    #1;
  endtask

  task automatic load(input logic [DW-1:0] d);
    step(0, 1, d, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("wgt_ready", 64'(wgt_ready), 64'(!rst && sh.size() < DEPTH));
      check("shadow_full", 64'(shadow_full), 64'(sh.size() == DEPTH));
      check("active_vld", 64'(active_vld), 64'(m_vld));
      check("swap_ack", 64'(swap_ack), 64'(m_ack));
      check("wgt_out", 64'(wgt_out), 64'(m_act));
      if (swap_ack) begin
        if (exp_q.size() == 0) check("swap_ack_unexpected", 64'(swap_ack), 64'd0);
        else                   check("promoted_set", 64'(wgt_out), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);

    // Basic load of 01..04 then swap; active must read tap0=04, tap3=01.
    load(8'h01); load(8'h02); load(8'h03); load(8'h04);
    idle();
    step(0, 0, '0, 1, 0);
    idle(); idle();

    // Swap while only two words loaded is ignored.
    step(1, 0, '0, 0, 0);
    load(8'hA1); load(8'hA2);
    step(0, 0, '0, 1, 0);
    idle();
    load(8'hA3); load(8'hA4);
    step(0, 0, '0, 1, 0);
    idle();

    // Producer holds 0x7F while full; it becomes first word after the swap.
    load(8'h11); load(8'h12); load(8'h13); load(8'h14);
    step(0, 1, 8'h7F, 0, 0);
    step(0, 1, 8'h7F, 0, 0);
    step(0, 1, 8'h7F, 0, 0);
    step(0, 1, 8'h7F, 1, 0);
    step(0, 1, 8'h7F, 0, 0);
    load(8'h21); load(8'h22); load(8'h23);
    step(0, 0, '0, 1, 0);
    idle();

    // Clear mid-load keeps the active set; clear with valid drops the word.
    load(8'h10); load(8'h20); load(8'h30); load(8'h40);
    step(0, 0, '0, 1, 0);
    load(8'h55); load(8'h66); load(8'h77);
    step(0, 1, 8'h99, 0, 1);
    idle();
    load(8'hC1); load(8'hC2); load(8'hC3); load(8'hC4);
    step(0, 0, '0, 1, 1);
    step(0, 0, '0, 1, 0);
    idle();

    // Sign patterns pass bit-exact.
    load(8'h80); load(8'hFF); load(8'h7F); load(8'h00);
    step(0, 0, '0, 1, 0);
    idle();

    // Reset mid-load with an active set present.
    load(8'h01); load(8'h02); load(8'h03);
    step(1, 0, '0, 0, 0);
    idle();
    load(8'h31); load(8'h32); load(8'h33); load(8'h34);
    step(1, 0, '0, 1, 0);
    idle();

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 60),
           DW'($urandom), ($urandom_range(99) < 25), ($urandom_range(99) < 5));
    end
    idle(); idle();

    #10;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
